// File: rtl/fc_layer_engine.sv
// Fully connected layer engine: buffers one activation vector, computes NUM_PE neurons
// per group against an external weight/bias memory, and streams saturated results out.
module fc_layer_engine #(
  parameter int DATA_WIDTH  = 12,
  parameter int INPUT_SIZE  = 400,
  parameter int OUTPUT_SIZE = 120,
  parameter int NUM_PE      = 4,
  parameter int ACC_WIDTH   = 32,
  parameter int FRAC_BITS   = 6,
  parameter int RELU_EN     = 1,
  localparam int NUM_GROUPS = OUTPUT_SIZE / NUM_PE,
  localparam int AW         = $clog2(NUM_GROUPS * (INPUT_SIZE + 1)),
  localparam int GW         = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         w_rd_en,
  output logic [AW-1:0]                w_addr,
  input  logic [NUM_PE*DATA_WIDTH-1:0] w_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_PE*DATA_WIDTH-1:0] out_data,
  output logic [GW-1:0]                out_group,
  output logic                         busy,
  output logic                         FC_done
);

  localparam int DW = DATA_WIDTH;
  localparam int KW = $clog2(INPUT_SIZE + 1);
  localparam int IW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(INPUT_SIZE - 1);
  localparam logic [KW-1:0] I_LAST = KW'(INPUT_SIZE);
  localparam logic [GW-1:0] G_LAST = GW'(NUM_GROUPS - 1);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {{(ACC_WIDTH-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {{(ACC_WIDTH-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_EMIT    = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e                        state_q;
  logic [KW-1:0]                 k_q;
  logic [KW-1:0]                 i_q;
  logic [GW-1:0]                 g_q;
  logic [AW-1:0]                 w_addr_q;
  logic                          w_rd_en_q;
  logic                          rd_vld_q;
  logic                          rd_bias_q;
  logic                          in_ready_q;
  logic                          out_valid_q;
  logic                          busy_q;
  logic                          fc_done_q;
  logic signed [DW-1:0]          act_q;
  logic [NUM_PE*DW-1:0]          out_data_q;
  logic [DW-1:0]                 vec_q [INPUT_SIZE];
  logic signed [ACC_WIDTH-1:0]   acc_q [NUM_PE];
  logic signed [ACC_WIDTH-1:0]   acc_d [NUM_PE];
  logic [NUM_PE*DW-1:0]          res_d;

  // Bias words are pre-scaled into the accumulator's fixed-point position.
  function automatic logic signed [ACC_WIDTH-1:0] mac_term(
    input logic signed [DW-1:0] a,
    input logic signed [DW-1:0] w,
    input logic                 is_bias
  );
    logic signed [2*DW-1:0] ax;
    logic signed [2*DW-1:0] wx;
    logic signed [2*DW-1:0] prod;
    ax   = {{DW{a[DW-1]}}, a};
    wx   = {{DW{w[DW-1]}}, w};
    prod = ax * wx;
    if (is_bias) begin
      mac_term = {{(ACC_WIDTH-DW){w[DW-1]}}, w} <<< FRAC_BITS;
    end else begin
      mac_term = {{(ACC_WIDTH-2*DW){prod[2*DW-1]}}, prod};
    end
  endfunction

  function automatic logic [DW-1:0] post_proc(input logic signed [ACC_WIDTH-1:0] acc);
    logic signed [ACC_WIDTH-1:0] sh;
    logic [DW-1:0]               r;
    sh = acc >>> FRAC_BITS;
    if (sh > SAT_MAX) begin
      r = SAT_MAX[DW-1:0];
    end else if (sh < SAT_MIN) begin
      r = SAT_MIN[DW-1:0];
    end else begin
      r = sh[DW-1:0];
    end
    post_proc = ((RELU_EN != 0) && r[DW-1]) ? {DW{1'b0}} : r;
  endfunction

  assign in_ready  = in_ready_q;
  assign w_rd_en   = w_rd_en_q;
  assign w_addr    = w_addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_group = g_q;
  assign busy      = busy_q;
  assign FC_done   = fc_done_q;

  // Accumulator next state: clear on the first issue, then fold in each returning word.
  always_comb begin
    for (int p = 0; p < NUM_PE; p++) begin
      if ((state_q == S_COMPUTE) && w_rd_en_q && (i_q == {KW{1'b0}})) begin
        acc_d[p] = {ACC_WIDTH{1'b0}};
      end else if (rd_vld_q) begin
        acc_d[p] = acc_q[p] + mac_term(act_q, $signed(w_data[p*DW +: DW]), rd_bias_q);
      end else begin
        acc_d[p] = acc_q[p];
      end
    end
  end

  // Scaled, saturated and rectified lane results, taken from the final accumulator value.
  always_comb begin
    res_d = {(NUM_PE*DW){1'b0}};
    for (int p = 0; p < NUM_PE; p++) begin
      res_d[p*DW +: DW] = post_proc(acc_d[p]);
    end
  end

  // Activation buffer; contents need no reset since every frame reloads it.
  always_ff @(posedge clk) begin
    if ((state_q == S_LOAD) && in_valid && in_ready_q) begin
      vec_q[k_q[IW-1:0]] <= in_data;
    end
  end

  // Control FSM, read pipeline and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= {KW{1'b0}};
      i_q         <= {KW{1'b0}};
      g_q         <= {GW{1'b0}};
      w_addr_q    <= {AW{1'b0}};
      w_rd_en_q   <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_bias_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      fc_done_q   <= 1'b0;
      act_q       <= {DW{1'b0}};
      out_data_q  <= {(NUM_PE*DW){1'b0}};
      for (int p = 0; p < NUM_PE; p++) begin
        acc_q[p] <= {ACC_WIDTH{1'b0}};
      end
    end else begin
      // Activation and word type travel one cycle behind the read so they meet w_data.
      rd_vld_q  <= w_rd_en_q;
      rd_bias_q <= w_rd_en_q && (i_q == I_LAST);
      if (i_q < I_LAST) begin
        act_q <= vec_q[i_q[IW-1:0]];
      end else begin
        act_q <= {DW{1'b0}};
      end
      for (int p = 0; p < NUM_PE; p++) begin
        acc_q[p] <= acc_d[p];
      end
      fc_done_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_LOAD;
            k_q        <= {KW{1'b0}};
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_LOAD: begin
          if (in_valid && in_ready_q) begin
            if (k_q == K_LAST) begin
              state_q    <= S_COMPUTE;
              in_ready_q <= 1'b0;
              i_q        <= {KW{1'b0}};
              g_q        <= {GW{1'b0}};
              w_addr_q   <= {AW{1'b0}};
              w_rd_en_q  <= 1'b1;
            end else begin
              k_q <= k_q + KW'(1);
            end
          end
        end
        S_COMPUTE: begin
          if (w_rd_en_q) begin
            if (i_q == I_LAST) begin
              w_rd_en_q <= 1'b0;
            end else begin
              i_q      <= i_q + KW'(1);
              w_addr_q <= w_addr_q + AW'(1);
            end
          end else if (rd_vld_q) begin
            out_data_q  <= res_d;
            out_valid_q <= 1'b1;
            state_q     <= S_EMIT;
          end else begin
            state_q <= S_COMPUTE;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (g_q == G_LAST) begin
              state_q   <= S_DONE;
              fc_done_q <= 1'b1;
            end else begin
              state_q   <= S_COMPUTE;
              g_q       <= g_q + GW'(1);
              i_q       <= {KW{1'b0}};
              w_addr_q  <= w_addr_q + AW'(1);
              w_rd_en_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          g_q      <= {GW{1'b0}};
          i_q      <= {KW{1'b0}};
          k_q      <= {KW{1'b0}};
          w_addr_q <= {AW{1'b0}};
        end
        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          w_rd_en_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_engine.sv
// Directed bench: two engines (ReLU on / off) run in lockstep on a small 4-in, 4-out,
// 2-lane configuration against a behavioural weight memory.
module tb_fc_layer_engine;

  localparam int DW = 12;
  localparam int IN = 4;
  localparam int PE = 2;
  localparam int AW = 4;
  localparam int GW = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [DW-1:0] in_data = 12'h000;

  logic r_in_ready, r_w_rd_en, r_out_valid, r_busy, r_fc_done;
  logic [AW-1:0] r_w_addr;
  logic [PE*DW-1:0] r_w_data = 24'h000000;
  logic [PE*DW-1:0] r_out_data;
  logic [GW-1:0] r_out_group;

  logic l_in_ready, l_w_rd_en, l_out_valid, l_busy, l_fc_done;
  logic [AW-1:0] l_w_addr;
  logic [PE*DW-1:0] l_w_data = 24'h000000;
  logic [PE*DW-1:0] l_out_data;
  logic [GW-1:0] l_out_group;

  logic [PE*DW-1:0] wmem [16];
  logic [DW-1:0] vec [IN];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fc_layer_engine #(
    .DATA_WIDTH(12), .INPUT_SIZE(4), .OUTPUT_SIZE(4), .NUM_PE(2),
    .ACC_WIDTH(32), .FRAC_BITS(0), .RELU_EN(1)
  ) u_relu (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(r_in_ready),
    .in_data(in_data), .w_rd_en(r_w_rd_en), .w_addr(r_w_addr), .w_data(r_w_data),
    .out_valid(r_out_valid), .out_ready(out_ready), .out_data(r_out_data),
    .out_group(r_out_group), .busy(r_busy), .FC_done(r_fc_done)
  );

  fc_layer_engine #(
    .DATA_WIDTH(12), .INPUT_SIZE(4), .OUTPUT_SIZE(4), .NUM_PE(2),
    .ACC_WIDTH(32), .FRAC_BITS(0), .RELU_EN(0)
  ) u_lin (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(l_in_ready),
    .in_data(in_data), .w_rd_en(l_w_rd_en), .w_addr(l_w_addr), .w_data(l_w_data),
    .out_valid(l_out_valid), .out_ready(out_ready), .out_data(l_out_data),
    .out_group(l_out_group), .busy(l_busy), .FC_done(l_fc_done)
  );

  // Weight memory with one-cycle read latency; junk on the bus when not reading.
  always @(posedge clk) begin
    r_w_data <= r_w_rd_en ? wmem[r_w_addr] : 24'hA5A5A5;
    l_w_data <= l_w_rd_en ? wmem[l_w_addr] : 24'hA5A5A5;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Group layout: address g*5+i, word = {lane1, lane0}.
  task automatic set_basic();
    for (int i = 0; i < 4; i++) wmem[i] = {12'hFFF, 12'h001};
    wmem[4] = {12'h000, 12'h000};
    wmem[5] = {12'h000, 12'h002};
    wmem[6] = {12'h000, 12'h000};
    wmem[7] = {12'hFFF, 12'h000};
    wmem[8] = {12'h000, 12'h000};
    wmem[9] = {12'h001, 12'h005};
    vec[0] = 12'd1; vec[1] = 12'd2; vec[2] = 12'd3; vec[3] = 12'd4;
  endtask

  task automatic set_sat();
    for (int i = 0; i < 4; i++) wmem[i] = {12'h800, 12'h7FF};
    wmem[4] = {12'h000, 12'h000};
    for (int i = 5; i < 9; i++) wmem[i] = {12'h000, 12'h000};
    wmem[9] = {12'h800, 12'h7FF};
    for (int i = 0; i < IN; i++) vec[i] = 12'h7FF;
  endtask

  task automatic load_vec(input bit bubbly);
    int k = 0;
    int guard = 0;
    while (k < IN && guard < 200) begin
      bit go;
      bit accept;
      go = bubbly ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_valid = go;
      in_data = go ? vec[k] : 12'hABC;
      accept = go && r_in_ready;
      tick();
      if (accept) k++;
      guard++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_group(output bit seen, output int cycles, output int rds);
    seen = 1'b0;
    cycles = 0;
    rds = 0;
    while (!seen && cycles < 100) begin
      if (r_w_rd_en) rds++;
      tick();
      cycles++;
      seen = r_out_valid;
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    tests++;
    if ({r_in_ready, r_w_rd_en, r_w_addr, r_out_valid, r_out_data, r_out_group, r_busy, r_fc_done} !== 34'h0) begin
      fails++;
      $display("FAIL reset_relu_outputs: got %h want 0", {r_in_ready, r_w_rd_en, r_w_addr, r_out_valid, r_out_data, r_out_group, r_busy, r_fc_done});
    end
    tests++;
    if ({l_in_ready, l_w_rd_en, l_w_addr, l_out_valid, l_out_data, l_out_group, l_busy, l_fc_done} !== 34'h0) begin
      fails++;
      $display("FAIL reset_lin_outputs: got %h want 0", {l_in_ready, l_w_rd_en, l_w_addr, l_out_valid, l_out_data, l_out_group, l_busy, l_fc_done});
    end
    tick();
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    tests++;
    if ({r_in_ready, r_busy} !== 2'b00) begin
      fails++;
      $display("FAIL idle_no_start: got ready/busy %b want 00", {r_in_ready, r_busy});
    end
  endtask

  task automatic test_basic();
    bit seen;
    int cyc;
    int rds;
    set_basic();
    pulse_start();
    tests++;
    if ({r_busy, l_busy, r_in_ready} !== 3'b111) begin
      fails++;
      $display("FAIL basic_load_entry: got busy/busy/ready %b want 111", {r_busy, l_busy, r_in_ready});
    end
    load_vec(1'b0);
    wait_group(seen, cyc, rds);
    tests++;
    if (!seen || cyc != IN + 2) begin
      fails++;
      $display("FAIL basic_g0_latency: got seen=%0d cycles=%0d want 1/%0d", seen, cyc, IN + 2);
    end
    tests++;
    if (rds != IN + 1) begin
      fails++;
      $display("FAIL basic_g0_reads: got %0d want %0d", rds, IN + 1);
    end
    tests++;
    if ({r_out_group, r_out_data} !== {1'b0, 24'h00000A}) begin
      fails++;
      $display("FAIL basic_g0_relu: got %h want %h", {r_out_group, r_out_data}, {1'b0, 24'h00000A});
    end
    tests++;
    if (l_out_data !== 24'hFF600A) begin
      fails++;
      $display("FAIL basic_g0_lin: got %h want FF600A", l_out_data);
    end
    wait_group(seen, cyc, rds);
    tests++;
    if (!seen || cyc != IN + 3 || rds != IN + 1) begin
      fails++;
      $display("FAIL basic_g1_timing: got seen=%0d cycles=%0d reads=%0d want 1/%0d/%0d", seen, cyc, rds, IN + 3, IN + 1);
    end
    tests++;
    if ({r_out_group, r_out_data, l_out_data} !== {1'b1, 24'h000007, 24'hFFE007}) begin
      fails++;
      $display("FAIL basic_g1_data: got %h want %h", {r_out_group, r_out_data, l_out_data}, {1'b1, 24'h000007, 24'hFFE007});
    end
    tests++;
    if ({r_fc_done, r_busy} !== 2'b01) begin
      fails++;
      $display("FAIL basic_pre_done: got done/busy %b want 01", {r_fc_done, r_busy});
    end
    tick();
    tests++;
    if ({r_fc_done, l_fc_done, r_out_valid, r_busy} !== 4'b1101) begin
      fails++;
      $display("FAIL basic_done_pulse: got %b want 1101", {r_fc_done, l_fc_done, r_out_valid, r_busy});
    end
    tick();
    tests++;
    if ({r_fc_done, r_busy, l_busy} !== 3'b000) begin
      fails++;
      $display("FAIL basic_back_idle: got %b want 000", {r_fc_done, r_busy, l_busy});
    end
  endtask

  task automatic test_saturation();
    bit seen;
    int cyc;
    int rds;
    set_sat();
    pulse_start();
    load_vec(1'b0);
    wait_group(seen, cyc, rds);
    tests++;
    if (!seen || {r_out_data, l_out_data} !== {24'h0007FF, 24'h8007FF}) begin
      fails++;
      $display("FAIL sat_g0: got seen=%0d %h want %h", seen, {r_out_data, l_out_data}, {24'h0007FF, 24'h8007FF});
    end
    wait_group(seen, cyc, rds);
    tests++;
    if (!seen || {r_out_data, l_out_data} !== {24'h0007FF, 24'h8007FF}) begin
      fails++;
      $display("FAIL sat_g1_bias_limits: got seen=%0d %h want %h", seen, {r_out_data, l_out_data}, {24'h0007FF, 24'h8007FF});
    end
    tick();
    tick();
  endtask

  task automatic test_backpressure();
    bit seen;
    int cyc;
    int rds;
    set_basic();
    out_ready = 1'b0;
    pulse_start();
    load_vec(1'b0);
    wait_group(seen, cyc, rds);
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL bp_g0_seen: got 0 want 1");
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      tests++;
      if ({r_out_valid, r_w_rd_en, r_out_group, r_out_data, l_out_data} !== {1'b1, 1'b0, 1'b0, 24'h00000A, 24'hFF600A}) begin
        fails++;
        $display("FAIL bp_hold_%0d: got %h want %h", c, {r_out_valid, r_w_rd_en, r_out_group, r_out_data, l_out_data}, {1'b1, 1'b0, 1'b0, 24'h00000A, 24'hFF600A});
      end
    end
    out_ready = 1'b1;
    wait_group(seen, cyc, rds);
    tests++;
    if (!seen || {r_out_group, r_out_data, l_out_data, r_fc_done} !== {1'b1, 24'h000007, 24'hFFE007, 1'b0}) begin
      fails++;
      $display("FAIL bp_g1: got seen=%0d %h want %h", seen, {r_out_group, r_out_data, l_out_data, r_fc_done}, {1'b1, 24'h000007, 24'hFFE007, 1'b0});
    end
    tick();
    tests++;
    if (r_fc_done !== 1'b1) begin
      fails++;
      $display("FAIL bp_done_after_accept: got %b want 1", r_fc_done);
    end
    tick();
  endtask

  task automatic test_bubbly();
    bit seen;
    int cyc;
    int rds;
    set_basic();
    start = 1'b1;
    in_valid = 1'b1;
    in_data = 12'h123;
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    tests++;
    if (r_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bubbly_start_taken: got %b want 1", r_in_ready);
    end
    load_vec(1'b1);
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_group(seen, cyc, rds);
    tests++;
    if (!seen || {r_out_data, l_out_data} !== {24'h00000A, 24'hFF600A}) begin
      fails++;
      $display("FAIL bubbly_g0: got seen=%0d %h want %h", seen, {r_out_data, l_out_data}, {24'h00000A, 24'hFF600A});
    end
    wait_group(seen, cyc, rds);
    tests++;
    if (!seen || {r_out_data, l_out_data} !== {24'h000007, 24'hFFE007}) begin
      fails++;
      $display("FAIL bubbly_g1: got seen=%0d %h want %h", seen, {r_out_data, l_out_data}, {24'h000007, 24'hFFE007});
    end
    tick();
    tick();
    tick();
    tests++;
    if ({r_busy, r_in_ready, l_busy} !== 3'b000) begin
      fails++;
      $display("FAIL bubbly_no_restart: got %b want 000", {r_busy, r_in_ready, l_busy});
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    bit done_seen;
    int cyc;
    int rds;
    set_basic();
    pulse_start();
    load_vec(1'b0);
    wait_group(seen, cyc, rds);
    tick();
    tick();
    tick();
    tests++;
    if ({r_w_rd_en, r_out_group} !== 2'b11) begin
      fails++;
      $display("FAIL rst_mid_precondition: got rd_en/group %b want 11", {r_w_rd_en, r_out_group});
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({r_in_ready, r_w_rd_en, r_w_addr, r_out_valid, r_out_data, r_out_group, r_busy, r_fc_done,
         l_in_ready, l_w_rd_en, l_w_addr, l_out_valid, l_out_data, l_out_group, l_busy, l_fc_done} !== 68'h0) begin
      fails++;
      $display("FAIL rst_mid_outputs: got %h / %h want 0",
               {r_in_ready, r_w_rd_en, r_w_addr, r_out_valid, r_out_data, r_out_group, r_busy, r_fc_done},
               {l_in_ready, l_w_rd_en, l_w_addr, l_out_valid, l_out_data, l_out_group, l_busy, l_fc_done});
    end
    done_seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      done_seen = done_seen | r_fc_done | l_fc_done;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      done_seen = done_seen | r_fc_done | l_fc_done | r_busy;
    end
    tests++;
    if (done_seen !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_no_done: got %b want 0", done_seen);
    end
    pulse_start();
    load_vec(1'b0);
    wait_group(seen, cyc, rds);
    tests++;
    if (!seen || cyc != IN + 2 || {r_out_data, l_out_data} !== {24'h00000A, 24'hFF600A}) begin
      fails++;
      $display("FAIL rst_reload_g0: got seen=%0d cycles=%0d %h want %h", seen, cyc, {r_out_data, l_out_data}, {24'h00000A, 24'hFF600A});
    end
    wait_group(seen, cyc, rds);
    tests++;
    if (!seen || {r_out_data, l_out_data} !== {24'h000007, 24'hFFE007}) begin
      fails++;
      $display("FAIL rst_reload_g1: got seen=%0d %h want %h", seen, {r_out_data, l_out_data}, {24'h000007, 24'hFFE007});
    end
    tick();
    tests++;
    if ({r_fc_done, l_fc_done} !== 2'b11) begin
      fails++;
      $display("FAIL rst_reload_done: got %b want 11", {r_fc_done, l_fc_done});
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) wmem[i] = 24'h000000;
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_bubbly();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fc_layer_engine.md
Name: fc_layer_engine

Overview:
Parametrised fully connected layer for the LeNet-5 datapath; successor to the FC stub.
- Buffers one input feature vector of INPUT_SIZE words, streamed in.
- Computes OUTPUT_SIZE neurons, NUM_PE at a time, with signed fixed-point MACs against an external weight memory.
- Streams the results out in groups, with optional ReLU, then pulses FC_done.
- Sits between the last pooling/flatten stage and the next FC layer or the classifier.

Parameters:
- DATA_WIDTH, 12: signed fixed-point width of activations, weights, biases and outputs.
- INPUT_SIZE, 400: number of input activations per vector.
- OUTPUT_SIZE, 120: number of output neurons. Must be a multiple of NUM_PE.
- NUM_PE, 4: parallel MAC channels, i.e. neurons computed per group.
- ACC_WIDTH, 32: signed accumulator width. Must be at least 2*DATA_WIDTH + clog2(INPUT_SIZE+1).
- FRAC_BITS, 6: fractional bits of the fixed-point format.
- RELU_EN, 1: 1 clamps negative outputs to 0; 0 passes them through.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; starts a vector load. Honoured only in IDLE.
- in_valid  input  1  input activation valid
- in_ready  output  1  engine can accept an input activation
- in_data  input  DATA_WIDTH  input activation, in index order 0..INPUT_SIZE-1
- w_rd_en  output  1  weight memory read enable
- w_addr  output  clog2(OUTPUT_SIZE/NUM_PE*(INPUT_SIZE+1))  weight word address
- w_data  input  NUM_PE*DATA_WIDTH  weight word, valid exactly 1 cycle after w_rd_en. Lane p is bits [p*DW+:DW].
- out_valid  output  1  output group valid
- out_ready  input  1  downstream accepts the output group
- out_data  output  NUM_PE*DATA_WIDTH  NUM_PE neuron results. Lane p is neuron g*NUM_PE+p.
- out_group  output  clog2(OUTPUT_SIZE/NUM_PE)  group index g of out_data
- busy  output  1  high in every state except IDLE
- FC_done  output  1  one-cycle pulse when the last group is accepted

Behaviour:
- Reset (rst_n low, asynchronous): every output is 0; state goes to IDLE; counters and accumulators clear. The input buffer contents are don't-care.
- Reset mid-operation aborts immediately. The next frame needs a new start and a full reload.
- Weight memory layout, group g, word i:
  - Address is g*(INPUT_SIZE+1)+i.
  - i in 0..INPUT_SIZE-1: lane p holds the weight W[g*NUM_PE+p][i].
  - i = INPUT_SIZE: lane p holds the bias of that neuron.
- IDLE: in_ready=0. On start go to LOAD.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready beat writes buffer[k], then k increments.
  - After beat INPUT_SIZE-1, go to COMPUTE the next cycle.
  - in_valid while in_ready=0 is ignored (not consumed).
- COMPUTE:
  - Issues INPUT_SIZE+1 back-to-back reads (w_rd_en=1, i=0..INPUT_SIZE) for group g, one per cycle, no bubbles.
  - The accumulator clears on the i=0 issue cycle.
  - The pipeline registers buffer[i] alongside the read so that buffer[i] is aligned with the returning w_data.
  - Each returned data word at i<INPUT_SIZE: acc[p] += sext(buffer[i]) * sext(lane p). The product is 2*DW signed.
  - For i=INPUT_SIZE: acc[p] += sext(bias_p) <<< FRAC_BITS.
  - One cycle after the last issue, go to EMIT. w_rd_en is 0 outside issue cycles.
- EMIT:
  - Each lane is: acc >>> FRAC_BITS (arithmetic, truncates toward -inf), then saturated to [-2^(DW-1), 2^(DW-1)-1], then ReLU if RELU_EN.
  - The result is registered; out_valid=1 and out_group=g.
  - out_data and out_group stay stable while out_valid & !out_ready.
  - On acceptance: if g < OUTPUT_SIZE/NUM_PE-1, increment g and return to COMPUTE. Otherwise go to DONE.
- DONE: FC_done=1 for exactly one cycle, out_valid=0, then IDLE. The buffered vector is not reused.
- Latency: LOAD takes INPUT_SIZE cycles when fed at full rate. Each group takes INPUT_SIZE+2 cycles plus 1 cycle in EMIT when out_ready=1.
- Simultaneous start and in_valid in IDLE: start is taken; that in_valid beat is not consumed.
- start while busy is ignored.
- Counter wrap: k, i and g never exceed their terminal values; they reset to 0 on state entry.

Test Plan:
1. Config DW=12, FRAC=0, IN=4, OUT=4, PE=2, RELU=1. Input [1,2,3,4]. Group0: lane0 weights all 1, bias 0; lane1 weights all -1, bias 0. -> group0 out = {10, 0}. busy high from start until FC_done.
2. Same config with RELU_EN=0. -> group0 lane1 = -10 (0xFF6). Group1: lane0 weights [2,0,0,0], bias 5 -> 7.
3. Saturation, IN=4, FRAC=0. Input all 2047, weights all 2047. -> lane = 2047. Negative overflow with RELU_EN=0 -> -2048.
4. Backpressure: hold out_ready=0 for 20 cycles at group0. -> out_valid stays 1, out_data stable, w_rd_en=0. Release -> group1 proceeds; FC_done comes 1 cycle after the last acceptance.
5. Bubbly input: in_valid 50% random during LOAD. -> results identical to test 1. start pulsed mid-COMPUTE is ignored.
6. Assert rst_n low mid-COMPUTE of group1. -> all outputs 0 immediately, no FC_done. A new start and reload give the correct test-1 results.
